// File: rtl/obi_mem_responder_pkg.sv
// Shared constants and response type for the OBI memory responder.
package obi_mem_responder_pkg;

  localparam logic [31:0] OBI_RDATA_ERR   = 32'h0;
  localparam logic [63:0] MEM_BASE_ADDR   = 64'h0;
  localparam int unsigned OBI_MAX_LATENCY = 4;
  localparam int unsigned OBI_DW          = 32;

  typedef struct packed {
    logic              valid;
    logic [OBI_DW-1:0] data;
  } obi_rsp_t;

  // off is already rebased to the memory base; limit is the region size in bytes
  function automatic logic addr_in_range(input logic [63:0] off, input logic [63:0] limit);
    return off < limit;
  endfunction

endpackage

// File: rtl/obi_resp_pipe.sv
// Fixed-latency response shift register; only the valid bits are reset so data can be plain flops.
module obi_resp_pipe
  import obi_mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  obi_rsp_t          i_rsp,
  output logic              o_valid,
  output logic [OBI_DW-1:0] o_data
);

  logic [LATENCY-1:0] r_valid;
  logic [OBI_DW-1:0]  r_data [LATENCY];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_rsp.valid;
      for (int unsigned i = 1; i < LATENCY; i++) r_valid[i] <= r_valid[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    r_data[0] <= i_rsp.data;
    for (int unsigned i = 1; i < LATENCY; i++) r_data[i] <= r_data[i-1];
  end

  // Masking keeps rdata at zero whenever no response is presented, including after reset.
  assign o_valid = r_valid[LATENCY-1];
  assign o_data  = r_valid[LATENCY-1] ? r_data[LATENCY-1] : '0;

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory-side responder: byte-enabled word RAM with fixed-latency in-order responses.
module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [63:0] BASE_ADDR       = MEM_BASE_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [63:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        gnt_block_i
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0]     r_outstanding;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH_WORDS];
  logic              w_grant;
  logic [63:0]       w_off;
  logic              w_in_range;
  logic [AW-1:0]     w_idx;
  obi_rsp_t          w_rsp;

  assign gnt_o      = rst_ni & req_i & ~gnt_block_i & (r_outstanding < CW'(MAX_OUTSTANDING));
  assign w_grant    = req_i & gnt_o;
  assign w_off      = addr_i - BASE_ADDR;
  assign w_in_range = addr_in_range(w_off, 64'(DEPTH_WORDS) << 2);
  assign w_idx      = w_off[2 +: AW];

  always_ff @(posedge clk_i) begin
    if (w_grant && we_i && w_in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_i[i]) r_mem[w_idx][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read happens combinationally here and is captured by the first pipe stage at the grant edge.
  always_comb begin
    w_rsp.valid = w_grant;
    w_rsp.data  = OBI_RDATA_ERR;
    if (!we_i && w_in_range) w_rsp.data = r_mem[w_idx];
  end

  obi_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_rsp   (w_rsp),
    .o_valid (rvalid_o),
    .o_data  (rdata_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      case ({w_grant, rvalid_o})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_grant && !w_in_range) r_err <= 1'b1;
    end
  end

  assign err_o = r_err;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_outstanding <= CW'(MAX_OUTSTANDING));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rvalid_o && (r_outstanding == '0)));

endmodule
